// File: rtl/pot_scanner_pkg.sv
// Shared types and constants for the potentiometer scan sequencer.
// Imported by the interface, the averaging accumulator and the top.
package pot_scan_pkg;

    localparam int CH_W = 3;

    // Logical order LP, B1, B2, B3, HP, VOLUME; index 0 sits in the LSBs.
    localparam logic [17:0] DEFAULT_CH_MAP = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        UPDATE
    } scan_state_t;

endpackage

// File: rtl/pot_scanner_if.sv
// Bundle of A2D handshake and published results between the scanner and its neighbours.
// The scanner takes the master side; the A2D front end and the datapath consumers take the slave side.
interface pot_scanner_if #(
    parameter int NUM_CH = 6,
    parameter int RES_W  = 12
);
    import pot_scan_pkg::*;

    logic                    en;
    logic                    cnv_cmplt;
    logic [RES_W-1:0]        res;
    logic                    strt_cnv;
    logic [CH_W-1:0]         chnnl;
    logic [NUM_CH*RES_W-1:0] pot_val;
    logic [NUM_CH-1:0]       pot_vld;
    logic [NUM_CH-1:0]       to_err;
    logic                    scan_done;
    logic                    busy;

    modport master (
        input  en, cnv_cmplt, res,
        output strt_cnv, chnnl, pot_val, pot_vld, to_err, scan_done, busy
    );

    modport slave (
        output en, cnv_cmplt, res,
        input  strt_cnv, chnnl, pot_val, pot_vld, to_err, scan_done, busy
    );

endinterface

// File: rtl/pot_scanner_avg_accum.sv
// Oversampling accumulator: sums 2^AVG_LOG2 conversions and presents their truncated mean.
// done flags that the sample currently being added is the last one of the set.
module pot_avg_accum #(
    parameter int RES_W    = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             add,
    input  logic [RES_W-1:0] data,
    output logic             done,
    output logic [RES_W-1:0] mean
);
    localparam int ACC_W   = RES_W + AVG_LOG2;
    localparam int SAMP_W  = AVG_LOG2 + 1;
    localparam int SAMPLES = 1 << AVG_LOG2;

    logic [ACC_W-1:0]  acc;
    logic [SAMP_W-1:0] samp;

    // Wide enough for SAMPLES full-scale values, so the sum never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc  <= '0;
            samp <= '0;
        end else if (add) begin
            acc  <= acc + ACC_W'(data);
            samp <= samp + 1'b1;
        end
    end

    assign done = (samp == SAMP_W'(SAMPLES - 1));
    assign mean = acc[AVG_LOG2 +: RES_W];

endmodule

// File: rtl/pot_scanner.sv
// Scan sequencer: walks the logical channel list, oversamples each A2D channel and
// publishes per-channel means with valid flags, a scan-complete pulse and sticky timeout errors.
module pot_scanner
    import pot_scan_pkg::*;
#(
    parameter int                      NUM_CH   = 6,
    parameter int                      RES_W    = 12,
    parameter logic [NUM_CH*CH_W-1:0]  CH_MAP   = DEFAULT_CH_MAP,
    parameter int                      AVG_LOG2 = 2,
    parameter int                      TO_CYC   = 1024
) (
    input logic           clk,
    input logic           rst,
    pot_scanner_if.master bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

    scan_state_t             state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic [TO_W-1:0]         to_cnt;
    logic                    strt_cnv_q;
    logic [CH_W-1:0]         chnnl_q;
    logic [NUM_CH*RES_W-1:0] pot_val_q;
    logic [NUM_CH-1:0]       pot_vld_q;
    logic [NUM_CH-1:0]       to_err_q;
    logic                    scan_done_q;
    logic                    busy_q;

    logic                    timeout;
    logic                    chan_end;
    logic                    acc_add;
    logic                    acc_clear;
    logic                    acc_done;
    logic [RES_W-1:0]        acc_mean;

    function automatic logic [CH_W-1:0] map_ch(input logic [IDX_W-1:0] i);
        return CH_MAP[CH_W*int'(i) +: CH_W];
    endfunction

    // A completion in the terminal wait cycle counts as data, so it masks the timeout.
    assign timeout   = (state == WAIT) && !bus.cnv_cmplt && (to_cnt == TO_LAST);
    assign chan_end  = timeout || (state == UPDATE);
    assign acc_add   = (state == WAIT) && bus.cnv_cmplt;
    assign acc_clear = chan_end;
    assign idx_next  = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    pot_avg_accum #(
        .RES_W    (RES_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .add   (acc_add),
        .data  (bus.res),
        .done  (acc_done),
        .mean  (acc_mean)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            to_cnt      <= '0;
            strt_cnv_q  <= 1'b0;
            chnnl_q     <= map_ch('0);
            pot_val_q   <= '0;
            pot_vld_q   <= '0;
            to_err_q    <= '0;
            scan_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            strt_cnv_q  <= 1'b0;
            scan_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state      <= START;
                        strt_cnv_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (bus.cnv_cmplt) begin
                        if (acc_done) begin
                            state <= UPDATE;
                        end else begin
                            state      <= START;
                            strt_cnv_q <= 1'b1;
                        end
                    end else if (timeout) begin
                        to_err_q[idx] <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    pot_val_q[RES_W*int'(idx) +: RES_W] <= acc_mean;
                    pot_vld_q[idx]                      <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // en is only honoured here, so a channel already in progress always finishes.
            if (chan_end) begin
                idx         <= idx_next;
                chnnl_q     <= map_ch(idx_next);
                scan_done_q <= (idx == LAST_IDX);
                if (bus.en) begin
                    state      <= START;
                    strt_cnv_q <= 1'b1;
                end else begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign bus.strt_cnv  = strt_cnv_q;
    assign bus.chnnl     = chnnl_q;
    assign bus.pot_val   = pot_val_q;
    assign bus.pot_vld   = pot_vld_q;
    assign bus.to_err    = to_err_q;
    assign bus.scan_done = scan_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pot_scanner.sv
// Directed bench for pot_scanner: an A2D model answers each strt_cnv after a set latency
// with 12'h100+chnnl, optionally overridden, muted per channel, or delayed to the timeout edge.
module tb_pot_scanner;
    import pot_scan_pkg::*;

    localparam int NUM_CH   = 6;
    localparam int RES_W    = 12;
    localparam int AVG_LOG2 = 2;
    localparam int TO_CYC   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pot_scanner_if #(.NUM_CH(NUM_CH), .RES_W(RES_W)) bus ();

    pot_scanner #(
        .NUM_CH   (NUM_CH),
        .RES_W    (RES_W),
        .CH_MAP   (DEFAULT_CH_MAP),
        .AVG_LOG2 (AVG_LOG2),
        .TO_CYC   (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int         lat         = 20;
    int         mute_ch     = -1;
    int         ovr_ch      = -1;
    int         ovr_len     = 0;
    logic [11:0] ovr_data [4];
    logic       model_flush = 1'b1;
    logic       mon_clr     = 1'b1;

    int          cyc      = 0;
    int          done_cnt = 0;
    int          cmpl_cnt = 0;
    logic [2:0]  strt_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors look at the cycle just ending, so each pulse is counted once.
    always @(posedge clk) begin
        if (mon_clr) begin
            done_cnt <= 0;
            strt_log.delete();
        end else begin
            if (bus.scan_done) done_cnt <= done_cnt + 1;
            if (bus.strt_cnv) strt_log.push_back(bus.chnnl);
        end
    end

    // A2D model, driven on the falling edge.
    int         m_cnt     = 0;
    int         m_ovr_pos = 0;
    logic       m_pending = 1'b0;
    logic [2:0] m_ch      = 3'd0;

    always @(negedge clk) begin
        bus.cnv_cmplt = 1'b0;
        if (model_flush) begin
            m_pending = 1'b0;
            m_ovr_pos = 0;
        end else begin
            if (m_pending) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_pending     = 1'b0;
                    bus.cnv_cmplt = 1'b1;
                    cmpl_cnt      = cmpl_cnt + 1;
                    if (int'(m_ch) == ovr_ch && m_ovr_pos < ovr_len) begin
                        bus.res   = ovr_data[m_ovr_pos];
                        m_ovr_pos = m_ovr_pos + 1;
                    end else begin
                        bus.res = 12'h100 + 12'(m_ch);
                    end
                end
            end
            if (bus.strt_cnv && int'(bus.chnnl) != mute_ch) begin
                m_pending = 1'b1;
                m_cnt     = lat;
                m_ch      = bus.chnnl;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        bus.en      = 1'b0;
        mon_clr     = 1'b1;
        model_flush = 1'b1;
        repeat (2) tick();
        rst         = 1'b0;
        mon_clr     = 1'b0;
        model_flush = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check_output({pfx, "_pot_val"},   bus.pot_val,   '0);
        check_output({pfx, "_pot_vld"},   bus.pot_vld,   6'h00);
        check_output({pfx, "_to_err"},    bus.to_err,    6'h00);
        check_output({pfx, "_scan_done"}, bus.scan_done, 1'b0);
        check_output({pfx, "_busy"},      bus.busy,      1'b0);
        check_output({pfx, "_strt_cnv"},  bus.strt_cnv,  1'b0);
        check_output({pfx, "_chnnl"},     bus.chnnl,     3'd0);
    endtask

    function automatic logic [11:0] pv(input int i);
        return bus.pot_val[i*RES_W +: RES_W];
    endfunction

    function automatic int n_starts(input logic [2:0] ch);
        int n = 0;
        foreach (strt_log[k]) if (strt_log[k] == ch) n++;
        return n;
    endfunction

    initial begin
        logic [2:0] exp_order [6];
        int n;
        int base;
        int s_cyc;
        int e_cyc;
        exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        bus.en = 1'b0;

        // Full scan with defaults
        apply_reset();
        check_reset_state("t1_rst");
        bus.en = 1'b1;
        n = 0;
        while (bus.pot_vld != 6'h3F && n < 1000) begin tick(); n++; end
        check_output("t1_all_vld", bus.pot_vld, 6'h3F);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 500) begin tick(); n++; end
        check_output("t1_idle", bus.busy, 1'b0);
        check_output("t1_pot_val", bus.pot_val,
                     {12'h107, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100});
        check_output("t1_scan_done_cnt", done_cnt, 1);
        check_output("t1_strt_cnt", strt_log.size(), 28);
        for (int i = 0; i < 24; i++) check_output("t1_order", strt_log[i], exp_order[i/4]);

        // Averaging of 10,11,12,14 on channel 0
        ovr_ch = 0;
        ovr_data = '{12'd10, 12'd11, 12'd12, 12'd14};
        ovr_len = 4;
        apply_reset();
        bus.en = 1'b1;
        base = cmpl_cnt;
        n = 0;
        while (cmpl_cnt - base < 3 && n < 400) begin tick(); n++; end
        tick();
        check_output("t2_vld_after3", bus.pot_vld[0], 1'b0);
        n = 0;
        while (cmpl_cnt - base < 4 && n < 400) begin tick(); n++; end
        check_output("t2_vld_in_update", bus.pot_vld[0], 1'b0);
        tick();
        check_output("t2_vld_after4", bus.pot_vld[0], 1'b1);
        check_output("t2_mean", pv(0), 12'd11);
        check_output("t2_next_strt", bus.strt_cnv, 1'b1);
        check_output("t2_next_ch", bus.chnnl, 3'd1);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 500) begin tick(); n++; end

        // Channel 2 never answers
        ovr_ch = -1;
        ovr_len = 0;
        mute_ch = 2;
        apply_reset();
        bus.en = 1'b1;
        n = 0;
        while (!(bus.strt_cnv && bus.chnnl == 3'd2) && n < 1000) begin tick(); n++; end
        s_cyc = cyc;
        n = 0;
        while (bus.to_err == 6'h00 && n < 2000) begin tick(); n++; end
        e_cyc = cyc;
        check_output("t3_to_latency", e_cyc - s_cyc, TO_CYC + 1);
        check_output("t3_to_err", bus.to_err, 6'b000100);
        check_output("t3_resume_strt", bus.strt_cnv, 1'b1);
        check_output("t3_resume_ch", bus.chnnl, 3'd3);
        check_output("t3_vld", bus.pot_vld, 6'b000011);
        check_output("t3_val2", pv(2), 12'h000);
        n = 0;
        while (done_cnt < 2 && n < 4000) begin tick(); n++; end
        check_output("t3_two_scans", done_cnt, 2);
        check_output("t3_to_err_sticky", bus.to_err, 6'b000100);
        check_output("t3_vld_scan2", bus.pot_vld, 6'b111011);
        check_output("t3_val2_scan2", pv(2), 12'h000);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 2000) begin tick(); n++; end

        // en dropped during channel 1's second sample
        mute_ch = -1;
        apply_reset();
        bus.en = 1'b1;
        n = 0;
        while (n_starts(3'd1) < 2 && n < 1000) begin tick(); n++; end
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 500) begin tick(); n++; end
        check_output("t4_idle", bus.busy, 1'b0);
        check_output("t4_vld", bus.pot_vld, 6'b000011);
        check_output("t4_val1", pv(1), 12'h101);
        check_output("t4_ch1_starts", n_starts(3'd1), 4);
        check_output("t4_ch2_starts", n_starts(3'd2), 0);
        bus.en = 1'b1;
        n = 0;
        while (!bus.strt_cnv && n < 10) begin tick(); n++; end
        check_output("t4_resume_ch", bus.chnnl, 3'd2);

        // Reset in WAIT, completion arrives after reset
        ovr_ch = 0;
        ovr_data[0] = 12'hFFF;
        ovr_len = 1;
        apply_reset();
        bus.en = 1'b1;
        n = 0;
        while (!bus.strt_cnv && n < 10) begin tick(); n++; end
        repeat (18) tick();
        rst = 1'b1;
        bus.en = 1'b0;
        tick();
        check_reset_state("t5_rst");
        rst = 1'b0;
        repeat (3) tick();
        check_output("t5_stray_busy", bus.busy, 1'b0);
        check_output("t5_stray_val", bus.pot_val, '0);
        bus.en = 1'b1;
        n = 0;
        while (!bus.pot_vld[0] && n < 500) begin tick(); n++; end
        check_output("t5_vld0", bus.pot_vld[0], 1'b1);
        check_output("t5_val0", pv(0), 12'h100);
        bus.en = 1'b0;
        n = 0;
        while (bus.busy && n < 500) begin tick(); n++; end

        // Completion coincident with the timeout terminal cycle
        ovr_ch = -1;
        ovr_len = 0;
        lat = TO_CYC;
        apply_reset();
        bus.en = 1'b1;
        n = 0;
        while (!bus.pot_vld[0] && n < 5000) begin tick(); n++; end
        check_output("t6_vld0", bus.pot_vld[0], 1'b1);
        check_output("t6_to_err", bus.to_err, 6'h00);
        check_output("t6_val0", pv(0), 12'h100);
        bus.en = 1'b0;
        lat = 20;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
